// File: rtl/jam_cost_eval.sv
// Job-assignment cost evaluator: sums the eight ROM costs of each incoming
// permutation and reports the batch minimum total and how many permutations reach it.
module jam_cost_eval #(
  parameter int COST_W = 7,
  parameter int SUM_W  = 10,
  parameter int CNT_W  = 4
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              perm_valid,
  output logic              perm_ready,
  input  logic [23:0]       perm_data,
  input  logic              perm_last,
  output logic [2:0]        W,
  output logic [2:0]        J,
  input  logic [COST_W-1:0] Cost,
  output logic [SUM_W-1:0]  MinCost,
  output logic [CNT_W-1:0]  MatchCount,
  output logic              Valid,
  output logic              perm_err
);

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_CMP, S_DONE} state_e;

  state_e             state_q, state_d;
  logic               ready_q;
  logic [23:0]        perm_q;
  logic               last_q;
  logic [2:0]         idx_q;
  logic [SUM_W-1:0]   sum_q;
  logic [7:0]         seen_q;
  logic               dup_q;
  logic [SUM_W-1:0]   min_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [SUM_W-1:0]   min_cost_q;
  logic [CNT_W-1:0]   match_q;
  logic               valid_q;
  logic               err_q;

  logic               accept;
  logic               fetch;
  logic [2:0]         job;

  assign accept = (state_q == S_IDLE) && ready_q && perm_valid;
  assign fetch  = (state_q == S_FETCH);
  assign job    = perm_q[{2'b00, idx_q} * 5'd3 +: 3];

  assign perm_ready = ready_q;
  assign W          = fetch ? idx_q : 3'd0;
  assign J          = fetch ? job : 3'd0;
  assign MinCost    = min_cost_q;
  assign MatchCount = match_q;
  assign Valid      = valid_q;
  assign perm_err   = err_q;

  // NOTE: next-state takes a default before the case so no path leaves it unassigned (no latch).
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (accept) state_d = S_FETCH;
      S_FETCH: if (idx_q == 3'd7) state_d = S_FETCH == S_FETCH ? S_CMP : S_CMP;
      S_CMP:   state_d = last_q ? S_DONE : S_IDLE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: every register uses <= so all updates on an edge see the pre-edge values.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q    <= S_IDLE;
      ready_q    <= 1'b0;
      perm_q     <= '0;
      last_q     <= 1'b0;
      idx_q      <= '0;
      sum_q      <= '0;
      seen_q     <= '0;
      dup_q      <= 1'b0;
      min_q      <= '1;
      cnt_q      <= '0;
      min_cost_q <= '0;
      match_q    <= '0;
      valid_q    <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q <= state_d;
      // Ready is the registered image of "next state is IDLE", so it stays low
      // for the first cycle after reset release.
      ready_q <= (state_d == S_IDLE);
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (accept) begin
            perm_q <= perm_data;
            last_q <= perm_last;
            idx_q  <= '0;
            sum_q  <= '0;
            seen_q <= '0;
            dup_q  <= 1'b0;
          end
        end
        S_FETCH: begin
          sum_q <= sum_q + SUM_W'(Cost);
          if (seen_q[job]) dup_q <= 1'b1;
          seen_q[job] <= 1'b1;
          idx_q <= idx_q + 3'd1;
        end
        S_CMP: begin
          if (dup_q) begin
            err_q <= 1'b1;
          end else if (sum_q < min_q) begin
            min_q <= sum_q;
            cnt_q <= CNT_W'(1);
          end else if ((sum_q == min_q) && (cnt_q != '1)) begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        S_DONE: begin
          min_cost_q <= min_q;
          match_q    <= cnt_q;
          valid_q    <= 1'b1;
          min_q      <= '1;
          cnt_q      <= '0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_jam_cost_eval.sv
// Self-checking bench for jam_cost_eval: constant vectors, hand-written corner
// sequences, and randomized batches checked against a whole-batch cost model.
module tb_jam_cost_eval;

  localparam int COST_W = 7;
  localparam int SUM_W  = 10;
  localparam int CNT_W  = 4;

  logic              CLK = 1'b0;
  logic              RST = 1'b0;
  logic              perm_valid = 1'b0;
  logic              perm_ready;
  logic [23:0]       perm_data = '0;
  logic              perm_last = 1'b0;
  logic [2:0]        W;
  logic [2:0]        J;
  logic [COST_W-1:0] Cost;
  logic [SUM_W-1:0]  MinCost;
  logic [CNT_W-1:0]  MatchCount;
  logic              Valid;
  logic              perm_err;

  logic [COST_W-1:0] rom [8][8];
  assign Cost = rom[W][J];

  always #5 CLK = ~CLK;

  jam_cost_eval #(.COST_W(COST_W), .SUM_W(SUM_W), .CNT_W(CNT_W)) dut (
    .CLK(CLK), .RST(RST),
    .perm_valid(perm_valid), .perm_ready(perm_ready),
    .perm_data(perm_data), .perm_last(perm_last),
    .W(W), .J(J), .Cost(Cost),
    .MinCost(MinCost), .MatchCount(MatchCount),
    .Valid(Valid), .perm_err(perm_err)
  );

  int n_cmp  = 0;
  int n_fail = 0;

  // Monitor samples at the rising edge, before the DUT's registers update.
  int               cyc        = 0;
  int               err_seen   = 0;
  int               valid_seen = 0;
  int               valid_cyc  = 0;
  logic [SUM_W-1:0] got_min    = '0;
  logic [CNT_W-1:0] got_cnt    = '0;

  always @(posedge CLK) begin
    cyc++;
    if (perm_err === 1'b1) err_seen++;
    if (Valid === 1'b1) begin
      valid_seen++;
      valid_cyc = cyc - 1;  // Valid became visible after the previous edge
      got_min   = MinCost;
      got_cnt   = MatchCount;
    end
  end

  int          acc_cyc = 0;
  int          err_base = 0;
  int          valid_base = 0;
  logic [23:0] batch_q [$];

  typedef struct {
    logic [23:0] perm;
    int          rom_mode;
    int          exp_min;
    int          exp_cnt;
    int          exp_err;
  } vec_t;

  vec_t tbl [8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // 0: w*8+j  1: j  2: all 5  3: 0 on diagonal else w+j  4: random 0..3  5: random 0..127
  task automatic set_rom(input int mode);
    for (int w = 0; w < 8; w++) begin
      for (int j = 0; j < 8; j++) begin
        case (mode)
          0:       rom[w][j] = 7'(w * 8 + j);
          1:       rom[w][j] = 7'(j);
          2:       rom[w][j] = 7'd5;
          3:       rom[w][j] = (w == j) ? 7'd0 : 7'(w + j);
          4:       rom[w][j] = 7'($urandom_range(0, 3));
          default: rom[w][j] = 7'($urandom_range(0, 127));
        endcase
      end
    end
  endtask

  function automatic logic [23:0] rand_perm(input bit allow_dup);
    int          p [8];
    int          k;
    int          t;
    logic [23:0] r;
    for (int i = 0; i < 8; i++) p[i] = i;
    for (int i = 7; i > 0; i--) begin
      k = $urandom_range(0, i);
      t = p[i]; p[i] = p[k]; p[k] = t;
    end
    if (allow_dup && ($urandom_range(0, 3) == 0)) p[$urandom_range(0, 7)] = p[$urandom_range(0, 7)];
    r = '0;
    for (int i = 0; i < 8; i++) r[3*i +: 3] = 3'(p[i]);
    return r;
  endfunction

  // Whole-batch reference: collect the totals of duplicate-free permutations,
  // then take the minimum and count ties, capped at 15.
  task automatic model(output int mn, output int cnt, output int ndup);
    int          sums [$];
    int          used [8];
    int          s;
    bit          dup;
    logic [23:0] p;
    int          jb;
    ndup = 0;
    foreach (batch_q[i]) begin
      p = batch_q[i];
      s = 0;
      dup = 1'b0;
      for (int j = 0; j < 8; j++) used[j] = 0;
      for (int w = 0; w < 8; w++) begin
        jb = int'(p[3*w +: 3]);
        used[jb]++;
        s += int'(rom[w][jb]);
      end
      for (int j = 0; j < 8; j++) if (used[j] > 1) dup = 1'b1;
      if (dup) ndup++;
      else sums.push_back(s);
    end
    mn = 1023;
    cnt = 0;
    foreach (sums[i]) if (sums[i] < mn) mn = sums[i];
    foreach (sums[i]) if (sums[i] == mn) cnt++;
    if (cnt > 15) cnt = 15;
  endtask

  task automatic begin_batch();
    batch_q.delete();
    err_base   = err_seen;
    valid_base = valid_seen;
  endtask

  // Called at a falling edge; returns at the falling edge after the accept edge.
  task automatic send_perm(input logic [23:0] d, input logic last);
    int budget;
    budget = 0;
    perm_valid = 1'b1;
    perm_data  = d;
    perm_last  = last;
    while ((perm_ready !== 1'b1) && (budget < 40)) begin
      @(negedge CLK);
      budget++;
    end
    if (perm_ready !== 1'b1) begin
      check("perm_ready wait", 32'(perm_ready), 32'd1);
      perm_valid = 1'b0;
      return;
    end
    @(negedge CLK);
    acc_cyc = cyc;
    batch_q.push_back(d);
    perm_valid = 1'b0;
    perm_data  = 24'($urandom);
    perm_last  = 1'($urandom_range(0, 1));
  endtask

  task automatic finish_batch(input string name, input logic [23:0] d, input bit use_model,
                              input int exp_min_i, input int exp_cnt_i, input int exp_err_i);
    int budget;
    int exp_min;
    int exp_cnt;
    int exp_err;
    exp_min = exp_min_i;
    exp_cnt = exp_cnt_i;
    exp_err = exp_err_i;
    send_perm(d, 1'b1);
    if (use_model) model(exp_min, exp_cnt, exp_err);
    budget = 0;
    while ((valid_seen == valid_base) && (budget < 30)) begin
      @(negedge CLK);
      budget++;
    end
    repeat (3) @(negedge CLK);
    check($sformatf("%s valid_pulses", name), 32'(valid_seen - valid_base), 32'd1);
    check($sformatf("%s latency", name), 32'(valid_cyc - acc_cyc), 32'd10);
    check($sformatf("%s MinCost", name), 32'(got_min), 32'(exp_min));
    check($sformatf("%s MatchCount", name), 32'(got_cnt), 32'(exp_cnt));
    check($sformatf("%s perm_err_pulses", name), 32'(err_seen - err_base), 32'(exp_err));
    check($sformatf("%s MinCost_hold", name), 32'(MinCost), 32'(exp_min));
  endtask

  task automatic check_zero_outputs(input string tag);
    check($sformatf("%s W", tag), 32'(W), 32'd0);
    check($sformatf("%s J", tag), 32'(J), 32'd0);
    check($sformatf("%s perm_ready", tag), 32'(perm_ready), 32'd0);
    check($sformatf("%s Valid", tag), 32'(Valid), 32'd0);
    check($sformatf("%s perm_err", tag), 32'(perm_err), 32'd0);
    check($sformatf("%s MinCost", tag), 32'(MinCost), 32'd0);
    check($sformatf("%s MatchCount", tag), 32'(MatchCount), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int          budget;
    int          last_rdy;
    int          k;
    logic [23:0] cur;

    // Perm encodings: identity FAC688, reversed 053977, rotate-by-one 1F58D1,
    // identity with worker 4 moved to job 3 FAB688, everyone on job 0 000000.
    tbl[0] = '{24'hFAC688, 0, 252,  1, 0};
    tbl[1] = '{24'h053977, 0, 252,  1, 0};
    tbl[2] = '{24'hFAB688, 1, 1023, 0, 1};
    tbl[3] = '{24'hFAC688, 2, 40,   1, 0};
    tbl[4] = '{24'h1F58D1, 3, 56,   1, 0};
    tbl[5] = '{24'hFAC688, 3, 0,    1, 0};
    tbl[6] = '{24'h000000, 3, 1023, 0, 1};
    tbl[7] = '{24'h1F58D1, 1, 28,   1, 0};

    set_rom(0);
    repeat (2) @(negedge CLK);
    check_zero_outputs("in_reset");
    RST = 1'b1;
    check("ready before first edge", 32'(perm_ready), 32'd0);
    @(negedge CLK);
    check("ready after release", 32'(perm_ready), 32'd1);

    // Reset in the middle of FETCH discards everything.
    begin_batch();
    send_perm(24'hFAC688, 1'b1);
    budget = 0;
    while ((W !== 3'd4) && (budget < 20)) begin
      @(negedge CLK);
      budget++;
    end
    check("midfetch W", 32'(W), 32'd4);
    RST = 1'b0;
    #1;
    check_zero_outputs("async_reset");
    @(negedge CLK);
    RST = 1'b1;
    @(negedge CLK);
    check("ready after mid reset", 32'(perm_ready), 32'd1);
    repeat (12) @(negedge CLK);
    check("no Valid after mid reset", 32'(valid_seen - valid_base), 32'd0);
    check("no perm_err after mid reset", 32'(err_seen - err_base), 32'd0);

    // Two tied permutations under cost w*8+j.
    begin_batch();
    send_perm(24'hFAC688, 1'b0);
    finish_batch("two_tie", 24'h053977, 1'b0, 252, 2, 0);

    for (int i = 0; i < 8; i++) begin
      set_rom(tbl[i].rom_mode);
      begin_batch();
      finish_batch($sformatf("vec%0d", i), tbl[i].perm, 1'b0, tbl[i].exp_min, tbl[i].exp_cnt, tbl[i].exp_err);
    end

    // Twenty ties saturate the counter.
    set_rom(2);
    begin_batch();
    for (int i = 0; i < 19; i++) send_perm(rand_perm(1'b0), 1'b0);
    finish_batch("saturate", rand_perm(1'b0), 1'b0, 40, 15, 0);

    // Duplicate permutation followed by a clean one.
    set_rom(1);
    begin_batch();
    send_perm(24'hFAB688, 1'b0);
    finish_batch("dup_then_id", 24'hFAC688, 1'b0, 28, 1, 1);

    // Every permutation duplicated, the last one included.
    set_rom(0);
    begin_batch();
    send_perm(24'h000000, 1'b0);
    finish_batch("all_dup", 24'hFAB688, 1'b0, 1023, 0, 2);

    // perm_valid held high: ready every 10 cycles, W/J walk the permutation.
    set_rom(0);
    begin_batch();
    perm_valid = 1'b1;
    perm_last  = 1'b0;
    perm_data  = rand_perm(1'b0);
    last_rdy   = -1;
    k          = -1;
    cur        = '0;
    for (int c = 0; c < 45; c++) begin
      if (perm_ready === 1'b1) begin
        if (last_rdy >= 0) check("stream ready period", 32'(cyc - last_rdy), 32'd10);
        last_rdy = cyc;
        cur = perm_data;
        batch_q.push_back(cur);
        k = 0;
      end else if ((k >= 0) && (k < 8)) begin
        check($sformatf("stream W/J k%0d", k), 32'({W, J}), 32'({3'(k), cur[3*k +: 3]}));
        if (k == 0) perm_data = rand_perm(1'b0);
        k++;
      end else if (k == 8) begin
        check("stream W/J outside fetch", 32'({W, J}), 32'd0);
        k = -1;
      end
      @(negedge CLK);
    end
    perm_valid = 1'b0;
    finish_batch("stream", rand_perm(1'b0), 1'b1, 0, 0, 0);

    // Randomized batches against the model.
    for (int b = 0; b < 6; b++) begin
      set_rom((b % 2 == 0) ? 4 : 5);
      begin_batch();
      for (int i = 0; i < int'($urandom_range(0, 5)); i++) send_perm(rand_perm(1'b1), 1'b0);
      finish_batch($sformatf("rand%0d", b), rand_perm(1'b1), 1'b1, 0, 0, 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/jam_cost_eval.md
Name: jam_cost_eval

Overview:
- Downstream stage of the job-assignment permutation generator.
- Consumes one worker-to-job permutation at a time over a valid/ready handshake.
- For each permutation, fetches the 8 matching costs from the cost ROM through the W/J/Cost port and sums them.
- Tracks the minimum total cost and how many permutations reach it; reports both when the permutation marked last has been evaluated.

Parameters:
- COST_W, 7, width of one cost entry.
- SUM_W, 10, width of a total cost; 8 x 127 = 1016 fits.
- CNT_W, 4, width of the match counter, which saturates.

Ports:
- CLK  input  1  clock; all state updates on rising edge.
- RST  input  1  reset, asynchronous, active-low.
- perm_valid  input  1  perm_data/perm_last are valid.
- perm_ready  output  1  block can accept a permutation.
- perm_data  input  24  job for worker w in bits [3w+2:3w], w=0..7.
- perm_last  input  1  this is the final permutation of the batch.
- W  output  3  worker index to the cost ROM.
- J  output  3  job index to the cost ROM.
- Cost  input  COST_W  ROM data for the current W/J; combinational, sampled on the same edge.
- MinCost  output  SUM_W  minimum total cost of the batch.
- MatchCount  output  CNT_W  number of permutations at MinCost, saturating at 15.
- Valid  output  1  one-cycle pulse; MinCost/MatchCount are final.
- perm_err  output  1  one-cycle pulse; the evaluated permutation had a duplicate job.

Behaviour:
- Reset values (RST low, async): state=IDLE, W=0, J=0, MinCost=0, MatchCount=0, Valid=0, perm_err=0, perm_ready=0.
- Internal reset values: min_r=1023 (all ones), cnt_r=0, sum=0, idx=0, seen mask=0.
- perm_ready equals (state==IDLE) and is registered through the state.
- States: IDLE -> FETCH -> CMP -> (IDLE | DONE); DONE -> IDLE.
- IDLE:
  - On an edge with perm_valid & perm_ready: latch perm_data and perm_last, set idx=0, sum=0, seen=0, go to FETCH.
  - perm_data changes while not ready are ignored.
- FETCH, 8 cycles, idx = 0..7:
  - W=idx, J=perm[idx] are driven combinationally from idx and the latched permutation.
  - Each edge: sum += Cost (zero-extended to SUM_W).
  - Each edge: if seen[J] is already set, set dup flag; then set seen[J].
  - idx increments; after the idx=7 edge go to CMP.
- CMP, 1 cycle:
  - If dup: pulse perm_err; min_r/cnt_r unchanged.
  - Else if sum < min_r: min_r=sum, cnt_r=1.
  - Else if sum == min_r: cnt_r = cnt_r+1, saturating at 15.
  - Next state is DONE if the latched last flag is set, else IDLE.
- DONE, 1 cycle:
  - MinCost<=min_r and MatchCount<=cnt_r; both hold until the next DONE.
  - Valid=1 for exactly this cycle.
  - min_r reinitialised to 1023, cnt_r to 0, for the next batch.
- Throughput: 10 cycles per permutation (accept edge + 8 FETCH + CMP); last permutation +1 cycle DONE.
- Latency: Valid asserts 10 cycles after the accept edge of the last permutation.
- Boundaries:
  - Batch where every permutation has a duplicate job: Valid pulses with MinCost=1023, MatchCount=0.
  - A single-permutation batch (last on the first perm) is legal.
  - A CMP for a duplicate permutation that is also last still proceeds to DONE.
  - Cost values are unsigned; no overflow is possible within SUM_W.
  - RST low mid-FETCH/CMP/DONE: immediate return to reset values; the partial permutation and batch are discarded, and no Valid or perm_err pulse is produced.
  - W/J outside FETCH hold 0.

Test Plan:
- Reset mid-FETCH (assert RST at idx=4) -> all outputs 0, perm_ready=1 one cycle after RST release, next batch evaluated from scratch.
- ROM cost[w][j]=w*8+j; single identity perm (job w to worker w), last=1 -> sum 252; Valid 10 cycles after accept; MinCost=252, MatchCount=1.
- Same ROM; perms identity then reversed (job 7-w), last on the 2nd -> both sum 252; MinCost=252, MatchCount=2.
- ROM all entries 5; 20 distinct perms, last on the 20th -> MinCost=40, MatchCount=15 (saturated).
- ROM cost[w][j]=j; perm with two workers on job 3 then identity, last=1 -> perm_err pulses once; MinCost=28, MatchCount=1.
- perm_valid held high continuously -> perm_ready pulses once every 10 cycles; W sequence 0..7 and J match perm during every FETCH.
